// File: rtl/pixel_word_packer.sv
// Packs a stream of InWidth-bit pixels LSB-first into gap-free OutWidth-bit words.
// Optional flush zero-pads the last partial word and reports completion with flush_done.
module pixel_word_packer #(
    parameter int unsigned InWidth  = 12,
    parameter int unsigned OutWidth = 16
) (
    input  logic                clk,
    input  logic                rst_,
    input  logic [InWidth-1:0]  in_data,
    input  logic                in_ok,
    output logic                in_trigger,
    output logic [OutWidth-1:0] out_data,
    output logic                out_ok,
    input  logic                out_trigger,
    input  logic                flush,
    output logic                flush_done
);

    localparam int unsigned BufW  = InWidth + OutWidth;
    localparam int unsigned FillW = $clog2(BufW + 1);
    localparam logic [FillW-1:0] OutFill = FillW'(OutWidth);
    localparam logic [FillW-1:0] InFill  = FillW'(InWidth);

    logic [BufW-1:0]     pix_buf;
    logic [BufW-1:0]     buf_m;
    logic [BufW-1:0]     buf_d;
    logic [FillW-1:0]    fill_q;
    logic [FillW-1:0]    fill_m;
    logic [FillW-1:0]    fill_d;
    logic                flush_pending;
    logic                slot_free;
    logic                move;
    logic                done;
    logic [OutWidth-1:0] out_mask;
    logic [OutWidth-1:0] out_word;

    // Drain-then-accept evaluation; bits at or above fill_q are kept zero in pix_buf.
    always_comb begin
        slot_free  = !out_ok || out_trigger;
        move       = slot_free && ((fill_q >= OutFill) || (flush_pending && (fill_q != '0)));
        fill_m     = fill_q;
        buf_m      = pix_buf;
        if (move) begin
            fill_m = (fill_q >= OutFill) ? (fill_q - OutFill) : '0;
            buf_m  = pix_buf >> OutWidth;
        end
        in_trigger = rst_ && in_ok && !flush_pending && (fill_m <= OutFill);
        done       = flush_pending && (fill_q == '0) && slot_free;
        fill_d     = fill_m;
        buf_d      = buf_m;
        if (in_trigger) begin
            fill_d = fill_m + InFill;
            buf_d  = buf_m | (BufW'(in_data) << fill_m);
        end
    end

    // Padding mask: only the low fill_q bits of a partial word are real data.
    always_comb begin
        out_mask = '0;
        for (int i = 0; i < int'(OutWidth); i++) begin
            out_mask[i] = (FillW'(i) < fill_q);
        end
        out_word = pix_buf[OutWidth-1:0] & out_mask;
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            pix_buf       <= '0;
            fill_q        <= '0;
            out_data      <= '0;
            out_ok        <= 1'b0;
            flush_pending <= 1'b0;
            flush_done    <= 1'b0;
        end else begin
            pix_buf <= buf_d;
            fill_q  <= fill_d;
            if (move) begin
                out_data <= out_word;
                out_ok   <= 1'b1;
            end else if (slot_free) begin
                out_ok   <= 1'b0;
            end
            if (done) begin
                flush_pending <= 1'b0;
                flush_done    <= 1'b1;
            end else begin
                flush_done <= 1'b0;
                if (flush) begin
                    flush_pending <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pixel_word_packer.sv
// Scoreboard bench for pixel_word_packer: a bit-queue reference model predicts every output word.
module tb_pixel_word_packer;

    localparam int unsigned InWidth  = 12;
    localparam int unsigned OutWidth = 16;

    logic                clk = 1'b0;
    logic                rst_;
    logic [InWidth-1:0]  in_data;
    logic                in_ok;
    logic                in_trigger;
    logic [OutWidth-1:0] out_data;
    logic                out_ok;
    logic                out_trigger;
    logic                flush;
    logic                flush_done;

    always #5 clk = ~clk;

    pixel_word_packer #(.InWidth(InWidth), .OutWidth(OutWidth)) dut (
        .clk         (clk),
        .rst_        (rst_),
        .in_data     (in_data),
        .in_ok       (in_ok),
        .in_trigger  (in_trigger),
        .out_data    (out_data),
        .out_ok      (out_ok),
        .out_trigger (out_trigger),
        .flush       (flush),
        .flush_done  (flush_done)
    );

    int n_vec = 0;
    int n_err = 0;
    int ok_pct = 100;
    int trig_pct = 100;
    int acc_count = 0;
    int out_count = 0;
    bit flush_out = 1'b0;

    logic [InWidth-1:0]  src[$];
    bit                  bitq[$];
    logic [OutWidth-1:0] expq[$];
    logic [OutWidth-1:0] seen[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Source behaves like a FIFO read port: head word held until consumed.
    initial begin : driver
        bit acc;
        in_ok = 1'b0;
        in_data = '0;
        out_trigger = 1'b0;
        forever begin
            @(negedge clk);
            acc = rst_ && in_ok && in_trigger;
            @(posedge clk);
            #1;
            if (acc && src.size() > 0) void'(src.pop_front());
            in_data = (src.size() > 0) ? src[0] : '0;
            in_ok = (src.size() > 0) && (int'($urandom_range(99)) < ok_pct);
            out_trigger = int'($urandom_range(99)) < trig_pct;
        end
    end

    // Reference model: a flat bitstream, padded to a word boundary on flush.
    initial begin : monitor
        logic [OutWidth-1:0] wv;
        forever begin
            @(negedge clk);
            if (!rst_) begin
                bitq.delete();
                expq.delete();
                flush_out = 1'b0;
            end else begin
                if (in_trigger) chk("in_trigger_needs_in_ok", 32'(in_ok), 1);
                if (in_ok && in_trigger) begin
                    for (int i = 0; i < int'(InWidth); i++) bitq.push_back(in_data[i]);
                    acc_count++;
                end
                if (flush) begin
                    while ((bitq.size() % int'(OutWidth)) != 0) bitq.push_back(1'b0);
                end
                while (bitq.size() >= int'(OutWidth)) begin
                    for (int i = 0; i < int'(OutWidth); i++) wv[i] = bitq.pop_front();
                    expq.push_back(wv);
                end
                if (flush_done) begin
                    chk("flush_done_all_words_taken", 32'(expq.size()), 0);
                    chk("flush_done_out_ok", 32'(out_ok), 0);
                    flush_out = 1'b0;
                end else if (flush_out && !flush) begin
                    chk("in_trigger_while_pending", 32'(in_trigger), 0);
                end
                if (out_ok && out_trigger) begin
                    seen.push_back(out_data);
                    out_count++;
                    chk("out_word_expected", 32'(expq.size() > 0), 1);
                    if (expq.size() > 0) chk("out_data", 32'(out_data), 32'(expq.pop_front()));
                end
            end
        end
    end

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk);
            #1;
            if (src.size() == 0 && expq.size() == 0 && !out_ok) ok = 1'b1;
        end
        chk("drain_timeout", 32'(ok), 1);
    endtask

    task automatic flush_pulse();
        @(posedge clk);
        #2;
        flush = 1'b1;
        flush_out = 1'b1;
        @(posedge clk);
        #2;
        flush = 1'b0;
    endtask

    task automatic flush_wait(output int cyc);
        bit got = 1'b0;
        cyc = 0;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            #1;
            cyc++;
            if (flush_done) got = 1'b1;
        end
        chk("flush_done_timeout", 32'(got), 1);
    endtask

    task automatic do_flush(output int cyc);
        flush_pulse();
        flush_wait(cyc);
    endtask

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : main
        int c;
        int a0;
        int o0;
        bit got;
        logic [InWidth-1:0]  p0;
        logic [InWidth-1:0]  p1;
        logic [OutWidth-1:0] w;

        rst_ = 1'b0;
        flush = 1'b0;
        src.push_back(12'hABC);
        src.push_back(12'h123);
        src.push_back(12'h456);
        src.push_back(12'h789);
        repeat (3) @(negedge clk);
        #1;
        chk("rst_out_ok", 32'(out_ok), 0);
        chk("rst_out_data", 32'(out_data), 0);
        chk("rst_flush_done", 32'(flush_done), 0);
        chk("rst_in_trigger", 32'(in_trigger), 0);

        // Basic packing and first-word latency
        @(posedge clk);
        #1;
        rst_ = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("latency_before", 32'(out_ok), 0);
        @(negedge clk);
        #1;
        chk("latency_first", 32'(out_ok), 1);
        wait_idle();
        chk("basic_count", 32'(seen.size()), 3);
        w = (seen.size() > 0) ? seen[0] : '0;
        chk("basic_word0", 32'(w), 32'h3ABC);
        w = (seen.size() > 1) ? seen[1] : '0;
        chk("basic_word1", 32'(w), 32'h5612);
        w = (seen.size() > 2) ? seen[2] : '0;
        chk("basic_word2", 32'(w), 32'h7894);

        // Streaming at full rate
        seen.delete();
        @(negedge clk);
        a0 = acc_count;
        o0 = out_count;
        for (int i = 0; i < 16; i++) src.push_back(InWidth'(i));
        repeat (16) @(negedge clk);
        #1;
        chk("stream_accepts", 32'(acc_count - a0), 16);
        wait_idle();
        chk("stream_words", 32'(out_count - o0), 12);

        // Backpressure
        trig_pct = 0;
        @(negedge clk);
        a0 = acc_count;
        for (int i = 0; i < 6; i++) src.push_back(InWidth'($urandom));
        repeat (10) @(negedge clk);
        #1;
        chk("bp_accepts", 32'(acc_count - a0), 3);
        chk("bp_out_ok", 32'(out_ok), 1);
        chk("bp_head", 32'(out_data), (expq.size() > 0) ? 32'(expq[0]) : 32'hDEAD_BEEF);
        repeat (5) @(negedge clk);
        #1;
        chk("bp_still_accepts", 32'(acc_count - a0), 3);
        chk("bp_head_stable", 32'(out_data), (expq.size() > 0) ? 32'(expq[0]) : 32'hDEAD_BEEF);
        trig_pct = 100;
        wait_idle();
        do_flush(c);

        // Flush pads a lone pixel; a second flush while pending is ignored
        seen.delete();
        @(negedge clk);
        src.push_back(12'hFFF);
        repeat (3) @(negedge clk);
        flush_pulse();
        src.push_back(12'h5A5);
        @(posedge clk);
        #2;
        flush = 1'b1;
        @(posedge clk);
        #2;
        flush = 1'b0;
        flush_wait(c);
        chk("pad_count", 32'(seen.size()), 1);
        w = (seen.size() > 0) ? seen[0] : '0;
        chk("pad_word", 32'(w), 32'h0FFF);
        @(negedge clk);
        #1;
        chk("flush_done_one_cycle", 32'(flush_done), 0);
        repeat (3) @(negedge clk);
        do_flush(c);
        wait_idle();

        // Flush with nothing buffered
        o0 = out_count;
        do_flush(c);
        chk("flush_empty_latency", 32'(c), 2);
        repeat (3) @(negedge clk);
        #1;
        chk("flush_empty_no_word", 32'(out_count - o0), 0);

        // Flush with exactly one full word buffered
        trig_pct = 0;
        @(negedge clk);
        a0 = acc_count;
        o0 = out_count;
        for (int i = 0; i < 4; i++) src.push_back(InWidth'($urandom));
        repeat (8) @(negedge clk);
        trig_pct = 100;
        @(posedge clk);
        #2;
        trig_pct = 0;
        repeat (2) @(negedge clk);
        #1;
        chk("full_accepts", 32'(acc_count - a0), 4);
        flush_pulse();
        trig_pct = 100;
        flush_wait(c);
        repeat (3) @(negedge clk);
        #1;
        chk("full_flush_words", 32'(out_count - o0), 3);

        // Reset mid-frame
        trig_pct = 0;
        @(negedge clk);
        src.push_back(InWidth'($urandom));
        src.push_back(InWidth'($urandom));
        repeat (6) @(negedge clk);
        #1;
        chk("mid_out_ok_before_reset", 32'(out_ok), 1);
        #2;
        rst_ = 1'b0;
        #1;
        chk("mid_reset_out_ok", 32'(out_ok), 0);
        chk("mid_reset_out_data", 32'(out_data), 0);
        repeat (2) @(negedge clk);
        seen.delete();
        p0 = InWidth'($urandom);
        p1 = InWidth'($urandom);
        src.push_back(p0);
        src.push_back(p1);
        trig_pct = 100;
        @(posedge clk);
        #1;
        rst_ = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            #1;
            if (seen.size() > 0) got = 1'b1;
        end
        chk("post_reset_word_seen", 32'(got), 1);
        w = (seen.size() > 0) ? seen[0] : '0;
        chk("post_reset_word", 32'(w), 32'({p1[3:0], p0}));
        wait_idle();
        do_flush(c);

        // Randomized traffic with random flushes
        ok_pct = 70;
        trig_pct = 60;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(posedge clk);
            #2;
            if (src.size() < 3) src.push_back(InWidth'($urandom));
            if (flush) begin
                flush = 1'b0;
            end else if (!flush_out && int'($urandom_range(99)) < 2) begin
                flush = 1'b1;
                flush_out = 1'b1;
            end
        end
        @(posedge clk);
        #2;
        flush = 1'b0;
        ok_pct = 100;
        trig_pct = 100;
        wait_idle();
        if (flush_out) flush_wait(c);
        do_flush(c);
        wait_idle();
        chk("final_words_left", 32'(expq.size()), 0);
        chk("final_bits_left", 32'(bitq.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
